wishbone_classic_master: RTL and testbench

WISHBONE_CLASSIC_MASTER -- requirements
Module: wishbone_classic_master

---
 rtl/wishbone_classic_master.sv | 151 +++++++++++++++
 tb/tb_wishbone_classic_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_classic_master.sv
// Single-outstanding Wishbone classic bus master: a command/response stream
// pair in front of one cyc/stb cycle, terminated by ack, err or a cycle timeout.
module wishbone_classic_master #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BUS_WIDTH     = 4,
  parameter int unsigned TIMEOUT       = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_cmd_valid,
  output logic                       s_cmd_ready,
  input  logic                       s_cmd_we,
  input  logic [ADDRESS_WIDTH-1:0]   s_cmd_addr,
  input  logic [BUS_WIDTH*8-1:0]     s_cmd_data,
  input  logic [BUS_WIDTH-1:0]       s_cmd_sel,
  output logic                       m_rsp_valid,
  input  logic                       m_rsp_ready,
  output logic [BUS_WIDTH*8-1:0]     m_rsp_data,
  output logic                       m_rsp_err,
  output logic                       m_rsp_timeout,
  output logic                       m_wb_cyc,
  output logic                       m_wb_stb,
  output logic                       m_wb_we,
  output logic [ADDRESS_WIDTH-1:0]   m_wb_addr,
  output logic [BUS_WIDTH*8-1:0]     m_wb_data_o,
  output logic [BUS_WIDTH-1:0]       m_wb_sel,
  input  logic                       m_wb_ack,
  input  logic                       m_wb_err,
  input  logic [BUS_WIDTH*8-1:0]     m_wb_data_i
);

  localparam int unsigned DW = BUS_WIDTH * 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic                     cmd_ready_nxt;
  logic                     rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DW-1:0]            rsp_data_nxt;
  logic                     cyc_nxt, stb_nxt, we_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_nxt;
  logic [DW-1:0]            data_o_nxt;
  logic [BUS_WIDTH-1:0]     sel_nxt;

  // State and every output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      s_cmd_ready   <= 1'b0;
      m_rsp_valid   <= 1'b0;
      m_rsp_data    <= '0;
      m_rsp_err     <= 1'b0;
      m_rsp_timeout <= 1'b0;
      m_wb_cyc      <= 1'b0;
      m_wb_stb      <= 1'b0;
      m_wb_we       <= 1'b0;
      m_wb_addr     <= '0;
      m_wb_data_o   <= '0;
      m_wb_sel      <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      s_cmd_ready   <= cmd_ready_nxt;
      m_rsp_valid   <= rsp_valid_nxt;
      m_rsp_data    <= rsp_data_nxt;
      m_rsp_err     <= rsp_err_nxt;
      m_rsp_timeout <= rsp_timeout_nxt;
      m_wb_cyc      <= cyc_nxt;
      m_wb_stb      <= stb_nxt;
      m_wb_we       <= we_nxt;
      m_wb_addr     <= addr_nxt;
      m_wb_data_o   <= data_o_nxt;
      m_wb_sel      <= sel_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    cmd_ready_nxt   = s_cmd_ready;
    rsp_valid_nxt   = m_rsp_valid;
    rsp_data_nxt    = m_rsp_data;
    rsp_err_nxt     = m_rsp_err;
    rsp_timeout_nxt = m_rsp_timeout;
    cyc_nxt         = m_wb_cyc;
    stb_nxt         = m_wb_stb;
    we_nxt          = m_wb_we;
    addr_nxt        = m_wb_addr;
    data_o_nxt      = m_wb_data_o;
    sel_nxt         = m_wb_sel;

    case (state)
      IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (s_cmd_valid && s_cmd_ready) begin
          state_nxt     = BUS;
          cnt_nxt       = '0;
          cmd_ready_nxt = 1'b0;
          cyc_nxt       = 1'b1;
          stb_nxt       = 1'b1;
          we_nxt        = s_cmd_we;
          addr_nxt      = s_cmd_addr;
          data_o_nxt    = s_cmd_data;
          sel_nxt       = s_cmd_sel;
        end
      end

      BUS: begin
        cmd_ready_nxt = 1'b0;
        // Slave termination outranks the timeout, even in the final cycle
        if (m_wb_ack || m_wb_err) begin
          state_nxt       = RESP;
          cyc_nxt         = 1'b0;
          stb_nxt         = 1'b0;
          we_nxt          = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = m_wb_err;
          rsp_timeout_nxt = 1'b0;
          rsp_data_nxt    = (!m_wb_err && !m_wb_we) ? m_wb_data_i : '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt       = RESP;
          cyc_nxt         = 1'b0;
          stb_nxt         = 1'b0;
          we_nxt          = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_data_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      RESP: begin
        cmd_ready_nxt = 1'b0;
        if (m_rsp_valid && m_rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_classic_master.sv
// Self-checking bench for wishbone_classic_master: a scripted/random Wishbone
// slave and an outcome model derived from wait length, termination kind and TIMEOUT.
module tb_wishbone_classic_master;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 4;

  // Slave termination kinds
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_SILENT = 3;

  logic          tb_data_clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic          s_cmd_we = 1'b0;
  logic [AW-1:0] s_cmd_addr = '0;
  logic [31:0]   s_cmd_data = '0;
  logic [BW-1:0] s_cmd_sel = '0;
  logic          m_rsp_valid;
  logic          m_rsp_ready = 1'b0;
  logic [31:0]   m_rsp_data;
  logic          m_rsp_err;
  logic          m_rsp_timeout;
  logic          m_wb_cyc, m_wb_stb, m_wb_we;
  logic [AW-1:0] m_wb_addr;
  logic [31:0]   m_wb_data_o;
  logic [BW-1:0] m_wb_sel;
  logic          m_wb_ack = 1'b0;
  logic          m_wb_err = 1'b0;
  logic [31:0]   m_wb_data_i = '0;

  int checks = 0;
  int failures = 0;

  always #5 tb_data_clk = ~tb_data_clk;

  wishbone_classic_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT(TO)) dut (
    .clk(tb_data_clk), .rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_we(s_cmd_we),
    .s_cmd_addr(s_cmd_addr), .s_cmd_data(s_cmd_data), .s_cmd_sel(s_cmd_sel),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
    .m_rsp_err(m_rsp_err), .m_rsp_timeout(m_rsp_timeout),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we),
    .m_wb_addr(m_wb_addr), .m_wb_data_o(m_wb_data_o), .m_wb_sel(m_wb_sel),
    .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err), .m_wb_data_i(m_wb_data_i)
  );

  // One complete transaction: issue, play the slave, check the response,
  // stall the response for `hold` cycles while injecting stray slave activity.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input int wait_c, input int kind,
                         input int hold, input logic [31:0] rdata, input string tag);
    int  guard, n, exp_cyc;
    bit  term, exp_err, exp_to;
    logic [31:0] exp_data;
    term     = (kind != K_SILENT) && (wait_c + 1 <= int'(TO));
    exp_cyc  = term ? wait_c + 1 : int'(TO);
    exp_err  = !term || (kind != K_ACK);
    exp_to   = !term;
    exp_data = (term && kind == K_ACK && !we) ? rdata : 32'h0;

    guard = 0;
    while (s_cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge tb_data_clk);
      guard++;
    end
    checks++;
    if (s_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s cmd_ready_wait: got %b want 1", tag, s_cmd_ready);
    end
    s_cmd_valid = 1'b1; s_cmd_we = we; s_cmd_addr = addr; s_cmd_data = data; s_cmd_sel = sel;
    @(negedge tb_data_clk);
    s_cmd_valid = 1'b0; s_cmd_we = ~we; s_cmd_addr = $urandom; s_cmd_data = $urandom;
    s_cmd_sel = 4'($urandom);
    checks++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel} !==
        {1'b1, 1'b1, we, addr, data, sel}) begin
      failures++;
      $display("FAIL %s wb_issue: got cyc=%b stb=%b we=%b a=%h d=%h s=%h want 1 1 %b %h %h %h",
               tag, m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel,
               we, addr, data, sel);
    end

    n = 0;
    while (m_wb_cyc === 1'b1 && n < 20) begin
      n++;
      checks++;
      if ({m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel, s_cmd_ready} !==
          {1'b1, we, addr, data, sel, 1'b0}) begin
        failures++;
        $display("FAIL %s wb_hold cyc%0d: stb=%b we=%b a=%h d=%h s=%h rdy=%b", tag, n,
                 m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel, s_cmd_ready);
      end
      if (term && n == wait_c + 1) begin
        m_wb_ack = (kind != K_ERR); m_wb_err = (kind != K_ACK); m_wb_data_i = rdata;
      end else begin
        m_wb_ack = 1'b0; m_wb_err = 1'b0; m_wb_data_i = $urandom;
      end
      @(negedge tb_data_clk);
      m_wb_ack = 1'b0; m_wb_err = 1'b0;
    end
    checks++;
    if (n != exp_cyc) begin
      failures++;
      $display("FAIL %s cyc_cycles: got %0d want %0d", tag, n, exp_cyc);
    end
    checks++;
    if ({m_wb_stb, m_wb_we, m_rsp_valid, m_rsp_err, m_rsp_timeout, m_rsp_data} !==
        {1'b0, 1'b0, 1'b1, exp_err, exp_to, exp_data}) begin
      failures++;
      $display("FAIL %s rsp: stb=%b we=%b v=%b err=%b to=%b d=%h want 0 0 1 %b %b %h", tag,
               m_wb_stb, m_wb_we, m_rsp_valid, m_rsp_err, m_rsp_timeout, m_rsp_data,
               exp_err, exp_to, exp_data);
    end

    for (int i = 0; i < hold; i++) begin
      m_wb_ack = 1'($urandom); m_wb_err = 1'($urandom); m_wb_data_i = $urandom;
      @(negedge tb_data_clk);
      checks++;
      if ({m_rsp_valid, m_rsp_err, m_rsp_timeout, m_rsp_data, s_cmd_ready, m_wb_cyc} !==
          {1'b1, exp_err, exp_to, exp_data, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s rsp_hold%0d: v=%b err=%b to=%b d=%h rdy=%b cyc=%b", tag, i,
                 m_rsp_valid, m_rsp_err, m_rsp_timeout, m_rsp_data, s_cmd_ready, m_wb_cyc);
      end
    end
    m_wb_ack = 1'b0; m_wb_err = 1'b0;
    m_rsp_ready = 1'b1;
    @(negedge tb_data_clk);
    m_rsp_ready = 1'b0;
    checks++;
    if ({m_rsp_valid, s_cmd_ready, m_wb_cyc} !== 3'b010) begin
      failures++;
      $display("FAIL %s rsp_done: v=%b rdy=%b cyc=%b want 0 1 0", tag,
               m_rsp_valid, s_cmd_ready, m_wb_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge tb_data_clk);
    checks++;
    if ({s_cmd_ready, m_rsp_valid, m_rsp_data, m_rsp_err, m_rsp_timeout, m_wb_cyc, m_wb_stb,
         m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel} !== '0) begin
      failures++;
      $display("FAIL reset_values: rdy=%b v=%b d=%h err=%b to=%b cyc=%b stb=%b we=%b a=%h do=%h s=%h",
               s_cmd_ready, m_rsp_valid, m_rsp_data, m_rsp_err, m_rsp_timeout, m_wb_cyc,
               m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel);
    end
    rst = 1'b0;
    @(negedge tb_data_clk);
    checks++;
    if ({s_cmd_ready, m_wb_cyc} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: rdy=%b cyc=%b want 1 0", s_cmd_ready, m_wb_cyc);
    end
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'h4, 32'hAAAA_0000, 4'hF, 0, K_ACK, 0, 32'hDEAD_BEEF, "write");
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 32'h8, 32'h0, 4'hF, 3, K_ACK, 0, 32'h1234_5678, "read_wait");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h10, 32'h0, 4'h3, 0, K_SILENT, 1, 32'h0, "timeout");
  endtask

  task automatic test_ack_err_hold();
    run_txn(1'b0, 32'hC, 32'h0, 4'hF, 1, K_BOTH, 5, 32'hCAFE_F00D, "ack_err_hold");
    run_txn(1'b1, 32'h20, 32'h5555_AAAA, 4'h1, 2, K_ERR, 2, 32'h0, "err_write");
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 5),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, "random");
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    // Reset two cycles into the bus phase
    guard = 0;
    while (s_cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge tb_data_clk);
      guard++;
    end
    s_cmd_valid = 1'b1; s_cmd_we = 1'b0; s_cmd_addr = 32'h40; s_cmd_sel = 4'hF;
    @(negedge tb_data_clk);
    s_cmd_valid = 1'b0;
    @(negedge tb_data_clk);
    rst = 1'b1;
    @(negedge tb_data_clk);
    checks++;
    if ({m_wb_cyc, m_wb_stb, m_rsp_valid, s_cmd_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_bus: cyc=%b stb=%b v=%b rdy=%b want 0 0 0 0",
               m_wb_cyc, m_wb_stb, m_rsp_valid, s_cmd_ready);
    end
    rst = 1'b0;
    @(negedge tb_data_clk);
    checks++;
    if ({m_rsp_valid, s_cmd_ready, m_wb_cyc} !== 3'b010) begin
      failures++;
      $display("FAIL rst_bus_release: v=%b rdy=%b cyc=%b want 0 1 0",
               m_rsp_valid, s_cmd_ready, m_wb_cyc);
    end
    run_txn(1'b0, 32'h44, 32'h0, 4'hF, 1, K_ACK, 0, 32'h0BAD_CAFE, "after_rst_bus");

    // Reset while a response is pending
    s_cmd_valid = 1'b1; s_cmd_we = 1'b1; s_cmd_addr = 32'h48; s_cmd_data = 32'h1; s_cmd_sel = 4'hF;
    @(negedge tb_data_clk);
    s_cmd_valid = 1'b0;
    m_wb_ack = 1'b1;
    @(negedge tb_data_clk);
    m_wb_ack = 1'b0;
    checks++;
    if (m_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_resp_pre: v=%b want 1", m_rsp_valid);
    end
    rst = 1'b1;
    @(negedge tb_data_clk);
    rst = 1'b0;
    @(negedge tb_data_clk);
    checks++;
    if ({m_rsp_valid, s_cmd_ready, m_wb_cyc} !== 3'b010) begin
      failures++;
      $display("FAIL rst_resp: v=%b rdy=%b cyc=%b want 0 1 0", m_rsp_valid, s_cmd_ready, m_wb_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int low, resp;
    bit seen_high;
    logic [31:0] exp_d, d;
    low = 0; resp = 0; seen_high = 0; exp_d = '0;
    m_rsp_ready = 1'b1; s_cmd_valid = 1'b1; s_cmd_we = 1'b0; s_cmd_sel = 4'hF;
    for (int i = 0; i < 40; i++) begin
      s_cmd_addr = $urandom;
      @(negedge tb_data_clk);
      if (s_cmd_ready === 1'b1) begin
        checks++;
        if ({m_wb_cyc, m_rsp_valid} !== 2'b00) begin
          failures++;
          $display("FAIL b2b_accept_idle: cyc=%b v=%b want 0 0", m_wb_cyc, m_rsp_valid);
        end
      end
      if (m_rsp_valid === 1'b1) begin
        resp++;
        checks++;
        if ({m_rsp_err, m_rsp_data} !== {1'b0, exp_d}) begin
          failures++;
          $display("FAIL b2b_data: err=%b d=%h want 0 %h", m_rsp_err, m_rsp_data, exp_d);
        end
      end
      if (m_wb_cyc === 1'b1) begin
        if (seen_high && low > 0) begin
          checks++;
          if (low < 2) begin
            failures++;
            $display("FAIL b2b_cyc_gap: got %0d want >=2", low);
          end
        end
        low = 0; seen_high = 1;
      end else begin
        low++;
      end
      m_wb_ack = m_wb_cyc & m_wb_stb;
      d = $urandom;
      m_wb_data_i = d;
      if (m_wb_ack) exp_d = d;
    end
    s_cmd_valid = 1'b0;
    checks++;
    if (resp < 10) begin
      failures++;
      $display("FAIL b2b_throughput: got %0d responses want >=10", resp);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge tb_data_clk);
      m_wb_ack = m_wb_cyc & m_wb_stb;
    end
    m_wb_ack = 1'b0;
    m_rsp_ready = 1'b0;
    checks++;
    if ({m_wb_cyc, m_rsp_valid, s_cmd_ready} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_drain: cyc=%b v=%b rdy=%b want 0 0 1", m_wb_cyc, m_rsp_valid, s_cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_ack_err_hold();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
